// File: rtl/mux_arb_nx_pkg.sv
// Shared constants for the N-channel arbitrated data selector.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mux_arb_pkg;

    // FSM encodings: IDLE tracks the default channel, GRANT follows the owner.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Arbitration modes.
    localparam int MODE_PRIO = 0;   // lowest asserted index wins
    localparam int MODE_RR   = 1;   // search upward from rr pointer, wrapping

endpackage

// File: rtl/mux_arb_nx_rot_prio_enc.sv
// Rotating priority encoder: first asserted req at or above base, wrapping mod N.
// Latency: combinational.
// Backpressure: none; pure function of req/base.
// Ports: req[N-1:0], base[BW-1:0] in; found (any req), idx (winning channel) out.
module rot_prio_enc
    import mux_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int BW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [BW-1:0] base,
    output logic          found,
    output logic [BW-1:0] idx
);

    logic [N-1:0]  rot;   // req rotated so that bit 0 corresponds to channel base
    logic [BW-1:0] off;   // offset of the winner from base
    logic [BW:0]   sum;

    // Doubling req lets a plain right shift implement the wrap-around rotation.
    assign rot = N'({req, req} >> base);

    always_comb begin
        off   = '0;
        found = 1'b0;
        // Descending scan so the lowest set offset is the last assignment.
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off   = BW'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (BW + 1)'(N)) begin
            idx = BW'(sum - (BW + 1)'(N));
        end else begin
            idx = sum[BW-1:0];
        end
    end

endmodule

// File: rtl/mux_arb_nx.sv
// N-channel registered data selector with fixed-priority or round-robin arbitration.
// Latency: req sampled at edge k drives grant/busy/dout_valid/dout registered at edge k.
// Backpressure: owner holds grant until done pulse or req drop; others wait for IDLE.
// Ports: clk, reset (async active-low), req[N], done, data[N*WIDTH] in;
//        dout[WIDTH], dout_valid, grant[N] (one-hot), busy out.
module mux_arb_nx
    import mux_arb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int N          = 3,
    parameter int MODE       = MODE_PRIO,
    parameter int DEFAULT_CH = N - 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic               done,
    input  logic [N*WIDTH-1:0] data,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid,
    output logic [N-1:0]       grant,
    output logic               busy
);

    localparam int BW = $clog2(N);

    logic [WIDTH-1:0] data_arr [N];

    logic [0:0]       state_q,      state_d;
    logic [BW-1:0]    owner_q,      owner_d;
    logic [BW-1:0]    rr_ptr_q,     rr_ptr_d;
    logic [N-1:0]     grant_q,      grant_d;
    logic [WIDTH-1:0] dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;

    logic [BW-1:0]    enc_base;
    logic             enc_found;
    logic [BW-1:0]    enc_idx;
    logic             release_w;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign data_arr[g] = data[g*WIDTH +: WIDTH];
    end

    // Fixed priority is just the rotating search anchored at channel 0.
    assign enc_base = (MODE == MODE_RR) ? rr_ptr_q : '0;

    rot_prio_enc #(
        .N  (N),
        .BW (BW)
    ) u_enc (
        .req   (req),
        .base  (enc_base),
        .found (enc_found),
        .idx   (enc_idx)
    );

    // done and an owner req drop on the same edge collapse into one release.
    assign release_w = done | ~req[owner_q];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;

        if (state_q == ST_IDLE) begin
            if (enc_found) begin
                state_d          = ST_GRANT;
                owner_d          = enc_idx;
                grant_d          = '0;
                grant_d[enc_idx] = 1'b1;
                dout_d           = data_arr[enc_idx];
                dout_valid_d     = 1'b1;
            end else begin
                grant_d      = '0;
                dout_d       = data_arr[DEFAULT_CH];
                dout_valid_d = 1'b0;
            end
        end else begin
            if (release_w) begin
                state_d      = ST_IDLE;
                grant_d      = '0;
                dout_d       = data_arr[DEFAULT_CH];
                dout_valid_d = 1'b0;
                rr_ptr_d     = (owner_q == BW'(N - 1)) ? '0 : owner_q + 1'b1;
            end else begin
                dout_d       = data_arr[owner_q];
                dout_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign grant      = grant_q;
    assign busy       = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux_arb_nx.sv
// Bench for mux_arb_nx: one fixed-priority and one round-robin instance on shared inputs.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_mux_arb_nx;

    localparam int N   = 3;
    localparam int W   = 8;
    localparam int DEF = N - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   req;
    logic           done;
    logic [W-1:0]   d_ch [N];
    logic [N*W-1:0] data;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign data[g*W +: W] = d_ch[g];
    end

    logic [W-1:0] dout_p, dout_r;
    logic         valid_p, valid_r, busy_p, busy_r;
    logic [N-1:0] grant_p, grant_r;

    mux_arb_nx #(.WIDTH(W), .N(N), .MODE(0), .DEFAULT_CH(DEF)) u_prio (
        .clk(clk), .reset(reset), .req(req), .done(done), .data(data),
        .dout(dout_p), .dout_valid(valid_p), .grant(grant_p), .busy(busy_p)
    );

    mux_arb_nx #(.WIDTH(W), .N(N), .MODE(1), .DEFAULT_CH(DEF)) u_rr (
        .clk(clk), .reset(reset), .req(req), .done(done), .data(data),
        .dout(dout_r), .dout_valid(valid_r), .grant(grant_r), .busy(busy_r)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model, index 0 = fixed priority, 1 = round robin.
    int           m_busy  [2];
    int           m_owner [2];
    int           m_ptr   [2];
    logic [W-1:0] m_dout  [2];
    logic         m_valid [2];
    logic [N-1:0] m_grant [2];

    function automatic bit req_bit(int c);
        return ((req >> c) & 3'd1) != 3'd0;
    endfunction

    function automatic int pick(int m);
        int base;
        base = (m == 1) ? m_ptr[m] : 0;
        for (int k = 0; k < N; k++) begin
            if (req_bit((base + k) % N)) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_busy[m]  = 0;
            m_owner[m] = 0;
            m_ptr[m]   = 0;
            m_dout[m]  = '0;
            m_valid[m] = 1'b0;
            m_grant[m] = '0;
        end
    endfunction

    function automatic void model_edge();
        int win;
        if (reset == 1'b0) return;
        for (int m = 0; m < 2; m++) begin
            if (m_busy[m] == 0) begin
                win = pick(m);
                if (win >= 0) begin
                    m_busy[m]  = 1;
                    m_owner[m] = win;
                    m_grant[m] = N'(1 << win);
                    m_dout[m]  = d_ch[win];
                    m_valid[m] = 1'b1;
                end else begin
                    m_grant[m] = '0;
                    m_dout[m]  = d_ch[DEF];
                    m_valid[m] = 1'b0;
                end
            end else if (done || !req_bit(m_owner[m])) begin
                m_busy[m]  = 0;
                m_grant[m] = '0;
                m_valid[m] = 1'b0;
                m_dout[m]  = d_ch[DEF];
                m_ptr[m]   = (m_owner[m] + 1) % N;
            end else begin
                m_dout[m] = d_ch[m_owner[m]];
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        done  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req = N'($urandom);
            for (int c = 0; c < N; c++) d_ch[c] = W'($urandom);
            step();
            n_vec++;
            if ({dout_p, valid_p, grant_p, busy_p} !== '0) begin
                n_err++;
                $display("FAIL reset_hold_prio: dout=%h valid=%b grant=%b, want all zero", dout_p, valid_p, grant_p);
            end
            n_vec++;
            if ({dout_r, valid_r, grant_r, busy_r} !== '0) begin
                n_err++;
                $display("FAIL reset_hold_rr: dout=%h valid=%b grant=%b, want all zero", dout_r, valid_r, grant_r);
            end
        end
        req     = '0;
        d_ch[2] = 8'h5A;
        reset   = 1'b1;
        step();
        n_vec++;
        if (dout_p !== 8'h5A || valid_p !== 1'b0) begin
            n_err++;
            $display("FAIL reset_default_prio: dout=%h valid=%b, want 5a/0", dout_p, valid_p);
        end
        n_vec++;
        if (dout_r !== 8'h5A || valid_r !== 1'b0) begin
            n_err++;
            $display("FAIL reset_default_rr: dout=%h valid=%b, want 5a/0", dout_r, valid_r);
        end
    endtask

    task automatic test_fixed_priority();
        req     = 3'b110;
        d_ch[1] = 8'h11;
        d_ch[2] = 8'h22;
        step();
        n_vec++;
        if (grant_p !== 3'b010 || dout_p !== 8'h11 || valid_p !== 1'b1 || busy_p !== 1'b1) begin
            n_err++;
            $display("FAIL prio_grant: grant=%b dout=%h valid=%b busy=%b, want 010/11/1/1", grant_p, dout_p, valid_p, busy_p);
        end
        d_ch[1] = 8'h33;
        step();
        n_vec++;
        if (dout_p !== 8'h33) begin
            n_err++;
            $display("FAIL prio_data_follow: dout=%h, want 33", dout_p);
        end
    endtask

    task automatic test_hold_release();
        req = 3'b111;
        step();
        n_vec++;
        if (grant_p !== 3'b010) begin
            n_err++;
            $display("FAIL hold_grant: grant=%b, want 010", grant_p);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        n_vec++;
        if (grant_p !== 3'b000 || busy_p !== 1'b0 || valid_p !== 1'b0) begin
            n_err++;
            $display("FAIL release_idle: grant=%b busy=%b valid=%b, want 000/0/0", grant_p, busy_p, valid_p);
        end
        step();
        n_vec++;
        if (grant_p !== 3'b001) begin
            n_err++;
            $display("FAIL regrant_prio: grant=%b, want 001", grant_p);
        end
        // rr pointer moved past channel 1, so channel 2 is next.
        n_vec++;
        if (grant_r !== 3'b100) begin
            n_err++;
            $display("FAIL regrant_rr: grant=%b, want 100", grant_r);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_seq [4];
        exp_seq[0] = 3'b001;
        exp_seq[1] = 3'b010;
        exp_seq[2] = 3'b100;
        exp_seq[3] = 3'b001;
        pulse_reset();
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            done = 1'b0;
            step();
            n_vec++;
            if (grant_r !== exp_seq[i]) begin
                n_err++;
                $display("FAIL rr_seq[%0d]: grant=%b, want %b", i, grant_r, exp_seq[i]);
            end
            done = 1'b1;
            step();
            n_vec++;
            if (grant_r !== 3'b000) begin
                n_err++;
                $display("FAIL rr_gap[%0d]: grant=%b, want 000", i, grant_r);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_owner_drop();
        req = 3'b111;
        step();
        n_vec++;
        if (grant_p !== 3'b001) begin
            n_err++;
            $display("FAIL drop_setup: grant=%b, want 001", grant_p);
        end
        d_ch[2] = 8'hC3;
        req     = 3'b110;
        step();
        n_vec++;
        if (valid_p !== 1'b0 || dout_p !== 8'hC3 || grant_p !== 3'b000) begin
            n_err++;
            $display("FAIL drop_release: valid=%b dout=%h grant=%b, want 0/c3/000", valid_p, dout_p, grant_p);
        end
        pulse_reset();
        req = 3'b011;
        step();
        n_vec++;
        if (grant_r !== 3'b001) begin
            n_err++;
            $display("FAIL dual_setup: grant=%b, want 001", grant_r);
        end
        done = 1'b1;
        req  = 3'b010;
        step();
        done = 1'b0;
        n_vec++;
        if (grant_r !== 3'b000 || valid_r !== 1'b0) begin
            n_err++;
            $display("FAIL dual_release: grant=%b valid=%b, want 000/0", grant_r, valid_r);
        end
        req = 3'b111;
        step();
        n_vec++;
        if (grant_r !== 3'b010) begin
            n_err++;
            $display("FAIL dual_single_advance: grant=%b, want 010", grant_r);
        end
    endtask

    task automatic test_reset_mid_grant();
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({dout_p, valid_p, grant_p, busy_p, dout_r, valid_r, grant_r, busy_r} !== '0) begin
            n_err++;
            $display("FAIL async_clear: p=%h/%b/%b/%b r=%h/%b/%b/%b, want all zero",
                     dout_p, valid_p, grant_p, busy_p, dout_r, valid_r, grant_r, busy_r);
        end
        #2;
        reset = 1'b1;
        step();
        n_vec++;
        if (grant_p !== 3'b001 || dout_p !== d_ch[0]) begin
            n_err++;
            $display("FAIL post_reset_prio: grant=%b dout=%h, want 001/%h", grant_p, dout_p, d_ch[0]);
        end
        n_vec++;
        if (grant_r !== 3'b001 || dout_r !== d_ch[0]) begin
            n_err++;
            $display("FAIL post_reset_rr: grant=%b dout=%h, want 001/%h", grant_r, dout_r, d_ch[0]);
        end
    endtask

    task automatic test_random();
        pulse_reset();
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) req = N'($urandom);
            done = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < N; c++) d_ch[c] = W'($urandom);
            step();
            n_vec++;
            if (dout_p !== m_dout[0] || valid_p !== m_valid[0] || grant_p !== m_grant[0] ||
                busy_p !== (m_busy[0] != 0)) begin
                n_err++;
                $display("FAIL rand_prio[%0d]: got %h/%b/%b/%b want %h/%b/%b/%0d", i,
                         dout_p, valid_p, grant_p, busy_p, m_dout[0], m_valid[0], m_grant[0], m_busy[0]);
            end
            n_vec++;
            if (dout_r !== m_dout[1] || valid_r !== m_valid[1] || grant_r !== m_grant[1] ||
                busy_r !== (m_busy[1] != 0)) begin
                n_err++;
                $display("FAIL rand_rr[%0d]: got %h/%b/%b/%b want %h/%b/%b/%0d", i,
                         dout_r, valid_r, grant_r, busy_r, m_dout[1], m_valid[1], m_grant[1], m_busy[1]);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        done  = 1'b0;
        for (int c = 0; c < N; c++) d_ch[c] = '0;
        model_reset();
        test_reset();
        test_fixed_priority();
        test_hold_release();
        test_round_robin();
        test_owner_drop();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
